// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad press debouncer and 4-digit hex entry buffer
module keypad_entry #(
    parameter int WINDOW          = 400_000,
    parameter int RELEASE_WINDOWS = 3
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic [3:0]  row,
    input  logic [3:0]  dec_in,
    output logic        key_strobe,
    output logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        entry_valid,
    output logic [15:0] entry_value
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [3:0]    REL_LAST = 4'(RELEASE_WINDOWS - 1);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;

    state_t        state, state_nxt;
    logic [3:0]    rel_cnt, rel_nxt;
    logic [3:0]    row_meta, row_sync;
    logic [WW-1:0] win_cnt;
    logic          seen_low;
    logic          any_low, win_end, low_win, capture;

    assign any_low = (row_sync != 4'b1111);
    assign win_end = (win_cnt == WIN_LAST);
    assign low_win = seen_low | any_low;

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
            win_cnt  <= '0;
            seen_low <= 1'b0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            win_cnt  <= win_end ? '0 : win_cnt + 1'b1;
            if (win_end)
                seen_low <= 1'b0;
            else if (any_low)
                seen_low <= 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state   <= IDLE;
            rel_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            rel_cnt <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rel_nxt   = rel_cnt;
        if (win_end) begin
            case (state)
                IDLE:    if (low_win) state_nxt = CONFIRM;
                CONFIRM: state_nxt = low_win ? HELD : IDLE;
                HELD: begin
                    if (low_win) begin
                        rel_nxt = 4'd0;
                    end else if (rel_cnt == REL_LAST) begin
                        state_nxt = IDLE;
                        rel_nxt   = 4'd0;
                    end else begin
                        rel_nxt = rel_cnt + 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sampling a full window after detection gives the decoder time to see the pressed column.
    always_comb begin
        capture = 1'b0;
        if (win_end && state == CONFIRM && low_win)
            capture = 1'b1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            key_strobe <= 1'b0;
            key_code   <= 4'h0;
        end else begin
            key_strobe <= capture;
            if (capture)
                key_code <= dec_in;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            digits      <= 16'h0000;
            digit_count <= 3'd0;
            entry_valid <= 1'b0;
            entry_value <= 16'h0000;
        end else begin
            entry_valid <= 1'b0;
            if (key_strobe) begin
                case (key_code)
                    4'hA, 4'hB, 4'hD: ;
                    4'hC: begin
                        digits      <= 16'h0000;
                        digit_count <= 3'd0;
                    end
                    4'hE: if (digit_count != 3'd0) begin
                        digits      <= {4'h0, digits[15:4]};
                        digit_count <= digit_count - 3'd1;
                    end
                    4'hF: if (digit_count != 3'd0) begin
                        entry_value <= digits;
                        entry_valid <= 1'b1;
                        digits      <= 16'h0000;
                        digit_count <= 3'd0;
                    end
                    default: if (digit_count < 3'd4) begin
                        digits      <= {digits[11:0], key_code};
                        digit_count <= digit_count + 3'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - randomized press sequences checked against a digit-list model
module tb_keypad_entry;

    localparam int W  = 40;
    localparam int RW = 3;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b0;
    logic [3:0]  row        = 4'hF;
    logic [3:0]  dec_in     = 4'h0;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        entry_valid;
    logic [15:0] entry_value;

    keypad_entry #(.WINDOW(W), .RELEASE_WINDOWS(RW)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .row        (row),
        .dec_in     (dec_in),
        .key_strobe (key_strobe),
        .key_code   (key_code),
        .digits     (digits),
        .digit_count(digit_count),
        .entry_valid(entry_valid),
        .entry_value(entry_value)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    int strobe_cnt = 0;
    int strobe_cyc = 0;
    int ev_cnt     = 0;
    always @(negedge clk_100MHz) begin
        if (key_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
        end
        if (entry_valid) ev_cnt = ev_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: the entry is a list of digits, oldest first; the display shows the last four.
    logic [3:0]  mq[$];
    logic [15:0] m_entry = 16'h0000;
    int          m_ev;

    function automatic logic [15:0] model_value();
        logic [15:0] v = 16'h0000;
        foreach (mq[i]) v = {v[11:0], mq[i]};
        return v;
    endfunction

    task automatic model_key(input logic [3:0] k);
        m_ev = 0;
        if (k <= 4'h9) begin
            if (mq.size() < 4) mq.push_back(k);
        end else if (k == 4'hE) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end else if (k == 4'hC) begin
            mq.delete();
        end else if (k == 4'hF) begin
            if (mq.size() > 0) begin
                m_entry = model_value();
                m_ev    = 1;
                mq.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check_buffer(input string tag);
        chk({tag, "_digits"}, digits, model_value());
        chk({tag, "_count"}, digit_count, mq.size());
        chk({tag, "_entry_value"}, entry_value, m_entry);
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int rel);
        int s0, e0, t0, lat;
        s0 = strobe_cnt;
        e0 = ev_cnt;
        dec_in = k;
        row = 4'hF ^ (4'h1 << $urandom_range(0, 3));
        t0 = cyc;
        tick(hold);
        row = 4'hF;
        tick(rel);
        model_key(k);
        lat = strobe_cyc - t0;
        chk("press_strobes", strobe_cnt - s0, 1);
        chk("press_key_code", key_code, k);
        chk("press_latency", (lat >= W && lat <= 2 * W + 4), 1);
        chk("press_entry_pulses", ev_cnt - e0, m_ev);
        check_buffer("press");
    endtask

    initial begin
        int s0, e0, base, n;
        logic [3:0] k;

        tick(3);
        chk("rst_strobe", key_strobe, 0);
        chk("rst_key_code", key_code, 0);
        chk("rst_digits", digits, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_entry_valid", entry_valid, 0);
        chk("rst_entry_value", entry_value, 0);
        reset_n = 1'b1;
        base = cyc;

        press(4'h5, 200, 200);
        chk("key5_digits", digits, 16'h0005);
        press(4'hC, 120, 200);
        foreach (mq[i]) ;
        press(4'h1, 120, 200);
        press(4'h2, 150, 200);
        press(4'h3, 100, 220);
        press(4'h4, 130, 200);
        press(4'h7, 110, 200);
        chk("full_digits", digits, 16'h1234);
        press(4'hE, 120, 200);
        chk("bksp_digits", digits, 16'h0123);
        press(4'hF, 120, 200);
        chk("enter_value", entry_value, 16'h0123);
        e0 = ev_cnt;
        press(4'hF, 120, 200);
        chk("enter_empty_no_pulse", ev_cnt - e0, 0);

        // Short low pulse placed mid-window so it touches only one window.
        s0 = strobe_cnt;
        while ((cyc - base) % W != 10) tick(1);
        row = 4'b1101;
        tick(5);
        row = 4'hF;
        tick(4 * W);
        chk("bounce_no_strobe", strobe_cnt - s0, 0);
        check_buffer("bounce");

        for (int i = 0; i < 24; i++) begin
            k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) k = 4'($urandom_range(0, 9));
            press(k, $urandom_range(100, 160), $urandom_range(180, 260));
        end

        // Long hold with one-window dropouts, then reset while still held.
        s0 = strobe_cnt;
        dec_in = 4'h8;
        for (int i = 0; i < 5; i++) begin
            row = 4'b0111;
            tick(3 * W);
            row = 4'hF;
            tick(W);
        end
        row = 4'b0111;
        tick(30);
        chk("dropout_one_strobe", strobe_cnt - s0, 1);
        chk("dropout_key_code", key_code, 4'h8);
        model_key(4'h8);
        check_buffer("dropout");

        reset_n = 1'b0;
        tick(2);
        chk("midrst_strobe", key_strobe, 0);
        chk("midrst_key_code", key_code, 0);
        chk("midrst_digits", digits, 0);
        chk("midrst_count", digit_count, 0);
        chk("midrst_entry_valid", entry_valid, 0);
        chk("midrst_entry_value", entry_value, 0);
        mq.delete();
        m_entry = 16'h0000;
        s0 = strobe_cnt;
        reset_n = 1'b1;
        base = cyc;
        n = 0;
        while (strobe_cnt == s0 && n < 2 * W + 10) begin
            tick(1);
            n++;
        end
        chk("rerst_strobe_seen", strobe_cnt - s0, 1);
        chk("rerst_latency", (n >= W && n <= 2 * W + 4), 1);
        chk("rerst_key_code", key_code, 4'h8);
        tick(20);
        row = 4'hF;
        tick(200);
        model_key(4'h8);
        chk("rerst_single_strobe", strobe_cnt - s0, 1);
        check_buffer("rerst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
